// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: fetches over a req/ack port, decodes the latched IR
// and sequences EXEC/MEM/WB, driving datapath controls from the current state.
module multicycle_control #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_ack,
    input  logic            dmem_ack,
    input  logic            BrEq,
    input  logic            BrLT,
    output logic            imem_req,
    output logic            dmem_req,
    output logic            MemRw,
    output logic            ir_we,
    output logic            pc_we,
    output logic            PCSel,
    output logic            RegWEn,
    output logic [2:0]      ImmSel,
    output logic            ALUsrc1,
    output logic            ALUsrc2,
    output logic [3:0]      AluSEL,
    output logic            BrUn,
    output logic [2:0]      ldU,
    output logic [1:0]      WBSel,
    output logic            retire,
    output logic            illegal,
    output logic            bus_err,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // The counter only has to reach TIMEOUT-1; the next ack-less cycle is the trap.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t        cur;
    logic [31:0]   ir;
    logic [CW-1:0] wait_cnt;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
    logic valid_op, bad_branch, taken;
    logic unused_ir;

    assign opcode     = ir[6:0];
    assign funct3     = ir[14:12];
    assign is_r       = (opcode == OP_R);
    assign is_i       = (opcode == OP_I);
    assign is_load    = (opcode == OP_LOAD);
    assign is_store   = (opcode == OP_STORE);
    assign is_branch  = (opcode == OP_BRANCH);
    assign is_jal     = (opcode == OP_JAL);
    assign is_jalr    = (opcode == OP_JALR);
    assign is_lui     = (opcode == OP_LUI);
    assign is_auipc   = (opcode == OP_AUIPC);
    assign valid_op   = is_r | is_i | is_load | is_store | is_branch |
                        is_jal | is_jalr | is_lui | is_auipc;
    assign bad_branch = is_branch & (funct3[2:1] == 2'b01);
    assign unused_ir  = ^{ir[31], ir[29:15], ir[11:7]};
    assign state      = cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= FETCH;
            ir       <= '0;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            wait_cnt <= '0;
            case (cur)
                FETCH: begin
                    if (imem_ack) begin
                        ir  <= imem_rdata[31:0];
                        cur <= DECODE;
                    end else if (wait_cnt == LAST) begin
                        bus_err <= 1'b1;
                        cur     <= TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DECODE: begin
                    if (!valid_op || bad_branch) begin
                        illegal <= 1'b1;
                        cur     <= TRAP;
                    end else begin
                        cur <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_branch)
                        cur <= FETCH;
                    else if (is_load || is_store)
                        cur <= MEM;
                    else
                        cur <= WB;
                end
                MEM: begin
                    if (dmem_ack) begin
                        cur <= is_load ? WB : FETCH;
                    end else if (wait_cnt == LAST) begin
                        bus_err <= 1'b1;
                        cur     <= TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WB:      cur <= FETCH;
                TRAP:    cur <= TRAP;
                default: cur <= FETCH;
            endcase
        end
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:          taken = BrEq;
            3'b001:          taken = ~BrEq;
            3'b100, 3'b110:  taken = BrLT;
            3'b101, 3'b111:  taken = ~BrLT;
            default:         taken = 1'b0;
        endcase
    end

    // Operand/ALU selects follow the latched IR from DECODE until write-back.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        MemRw    = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        PCSel    = 1'b0;
        RegWEn   = 1'b0;
        ImmSel   = 3'b000;
        ALUsrc1  = 1'b0;
        ALUsrc2  = 1'b0;
        AluSEL   = 4'b0000;
        BrUn     = 1'b0;
        ldU      = 3'b000;
        WBSel    = 2'b00;
        retire   = 1'b0;

        if (cur == DECODE || cur == EXEC || cur == MEM || cur == WB) begin
            if (is_r) begin
                AluSEL = {ir[30], funct3};
            end else if (is_i) begin
                ALUsrc2 = 1'b1;
                AluSEL  = (funct3 == 3'b101) ? {ir[30], funct3} : {1'b0, funct3};
            end else if (is_load || is_jalr) begin
                ALUsrc2 = 1'b1;
            end else if (is_store) begin
                ALUsrc2 = 1'b1;
                ImmSel  = 3'b001;
            end else if (is_branch) begin
                ALUsrc1 = 1'b1;
                ALUsrc2 = 1'b1;
                ImmSel  = 3'b010;
                BrUn    = funct3[1];
            end else if (is_jal) begin
                ALUsrc1 = 1'b1;
                ALUsrc2 = 1'b1;
                ImmSel  = 3'b100;
            end else if (is_lui) begin
                ALUsrc2 = 1'b1;
                ImmSel  = 3'b011;
                AluSEL  = 4'b1111;
            end else if (is_auipc) begin
                ALUsrc1 = 1'b1;
                ALUsrc2 = 1'b1;
                ImmSel  = 3'b011;
            end
        end

        case (cur)
            FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ack;
            end
            EXEC: begin
                if (is_branch) begin
                    PCSel  = taken;
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                MemRw    = is_store;
                ldU      = funct3;
                if (dmem_ack && is_store) begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end
            end
            WB: begin
                RegWEn = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
                if (is_jal || is_jalr) begin
                    WBSel = 2'b00;
                    PCSel = 1'b1;
                end else if (is_load) begin
                    WBSel = 2'b10;
                end else begin
                    WBSel = 2'b01;
                end
            end
            default: ;
        endcase
    end

endmodule
